// File: rtl/pb_pkg.sv
// Shared types and default tuning for the pushbutton conditioner.
// Defaults assume the 100 Hz board clock.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } pb_state_t;

  localparam int         PB_DEBOUNCE     = 3;
  localparam int         PB_REPEAT_DELAY = 50;
  localparam int         PB_REPEAT_RATE  = 10;
  localparam logic [6:0] PB_REPEAT_MASK  = 7'b1111100;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_channel.sv
// One pushbutton: two-flop synchroniser, debounce, press/release pulses and
// hold-to-repeat state machine.
module pb_channel
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = PB_DEBOUNCE,
  parameter int REPEAT_DELAY   = PB_REPEAT_DELAY,
  parameter int REPEAT_RATE    = PB_REPEAT_RATE,
  parameter bit REPEAT_EN      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pb_raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int DW   = cnt_w(DEBOUNCE_TICKS);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = cnt_w(RMAX);

  localparam logic [DW-1:0] D_LAST       = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [RW-1:0] R_DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          stab_q, stab_d;
  pb_state_t     state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          rise, fall;

  always_comb begin
    s1_d   = pb_raw;
    s2_d   = s1_q;
    stab_d = stab_q;
    dcnt_d = '0;
    if (s2_q != stab_q) begin
      if (dcnt_q == D_LAST) begin
        stab_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // The FSM reacts to the level being accepted this edge, so press, release
  // and level all change on the same clock.
  assign rise = stab_d & ~stab_q;
  assign fall = ~stab_d & stab_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    press_d = 1'b0;
    rel_d   = fall;
    if (fall) begin
      // A release beats any repeat that would have fired on this edge.
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            press_d = 1'b1;
            state_d = HOLD;
            rcnt_d  = '0;
          end
        end
        HOLD: begin
          // Non-repeating channels park the counter at its terminal value.
          if (rcnt_q != R_DELAY_LAST) begin
            rcnt_d = rcnt_q + RW'(1);
          end else if (REPEAT_EN) begin
            press_d = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end
        end
        REPEAT: begin
          if (rcnt_q == R_RATE_LAST) begin
            press_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      dcnt_q  <= '0;
      stab_q  <= 1'b0;
      state_q <= IDLE;
      rcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dcnt_q  <= dcnt_d;
      stab_q  <= stab_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = stab_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/pb_conditioner.sv
// Conditions all world-clock pushbuttons into debounced levels and
// press/release pulses; release_pulse carries the release output (release is a keyword).
module pb_conditioner
  import pb_pkg::*;
#(
  parameter int                   N_BUTTONS      = 7,
  parameter int                   DEBOUNCE_TICKS = PB_DEBOUNCE,
  parameter int                   REPEAT_DELAY   = PB_REPEAT_DELAY,
  parameter int                   REPEAT_RATE    = PB_REPEAT_RATE,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK    = N_BUTTONS'(PB_REPEAT_MASK)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] pb_raw,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_pulse
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    pb_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .pb_raw        (pb_raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner: expected pulse events are queued with
// their due cycle and matched against the outputs every cycle.
module tb_pb_conditioner;

  localparam int K_ACC = 0;
  localparam int K_REP = 1;
  localparam int K_REL = 2;

  typedef struct {
    int cyc;
    int kind;
    int bidx;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] pb_raw;
  logic [6:0] level, press, release_pulse;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  ev_t        sb[$];
  logic [6:0] exp_level = '0;
  logic [6:0] ep, er;

  pb_conditioner dut (
    .clk           (clk),
    .reset         (reset),
    .pb_raw        (pb_raw),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_ev(input int kind, input int b, input int at);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.bidx = b;
    sb.push_back(e);
  endtask

  // Scoreboard: pop every event due this cycle and compare full vectors.
  always @(negedge clk) begin
    ep = '0;
    er = '0;
    if (reset) begin
      exp_level = '0;
    end else begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            K_ACC: begin ep[sb[i].bidx] = 1'b1; exp_level[sb[i].bidx] = 1'b1; end
            K_REP: ep[sb[i].bidx] = 1'b1;
            default: begin er[sb[i].bidx] = 1'b1; exp_level[sb[i].bidx] = 1'b0; end
          endcase
          sb.delete(i);
        end
      end
    end
    checks += 3;
    assert (press === ep) else begin
      errors++;
      $error("FAIL press cyc=%0d observed=%b expected=%b", cyc, press, ep);
    end
    assert (release_pulse === er) else begin
      errors++;
      $error("FAIL release cyc=%0d observed=%b expected=%b", cyc, release_pulse, er);
    end
    assert (level === exp_level) else begin
      errors++;
      $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, level, exp_level);
    end
  end

  initial begin
    int t;
    int a;
    // Reset while all buttons are held; acceptance after deassertion.
    reset  = 1'b1;
    pb_raw = 7'h7F;
    tick(4);
    reset = 1'b0;
    t = cyc;
    for (int b = 0; b < 7; b++) expect_ev(K_ACC, b, t + 5);
    tick(15);
    pb_raw = '0;
    t = cyc;
    for (int b = 0; b < 7; b++) expect_ev(K_REL, b, t + 5);
    tick(10);

    // Two-sample glitch is rejected, three-sample pulse is accepted.
    pb_raw[3] = 1'b1;
    tick(2);
    pb_raw[3] = 1'b0;
    tick(10);
    pb_raw[3] = 1'b1;
    t = cyc;
    expect_ev(K_ACC, 3, t + 5);
    tick(3);
    pb_raw[3] = 1'b0;
    expect_ev(K_REL, 3, t + 8);
    tick(10);

    // Hold-to-repeat on pb[4].
    pb_raw[4] = 1'b1;
    a = cyc + 5;
    expect_ev(K_ACC, 4, a);
    expect_ev(K_REP, 4, a + 50);
    expect_ev(K_REP, 4, a + 60);
    expect_ev(K_REP, 4, a + 70);
    tick(75);
    pb_raw[4] = 1'b0;
    expect_ev(K_REL, 4, a + 75);
    tick(20);

    // Unmasked pb[1] held a long time gives a single press.
    pb_raw[1] = 1'b1;
    t = cyc;
    expect_ev(K_ACC, 1, t + 5);
    tick(205);
    pb_raw[1] = 1'b0;
    expect_ev(K_REL, 1, cyc + 5);
    tick(10);

    // Release landing exactly on a repeat boundary of pb[5].
    pb_raw[5] = 1'b1;
    a = cyc + 5;
    expect_ev(K_ACC, 5, a);
    expect_ev(K_REP, 5, a + 50);
    expect_ev(K_REP, 5, a + 60);
    tick(70);
    pb_raw[5] = 1'b0;
    expect_ev(K_REL, 5, a + 70);
    tick(20);
    // A fresh tap behaves normally, so the channel returned to idle.
    pb_raw[5] = 1'b1;
    expect_ev(K_ACC, 5, cyc + 5);
    tick(20);
    pb_raw[5] = 1'b0;
    expect_ev(K_REL, 5, cyc + 5);
    tick(10);

    // Simultaneous pb[2]/pb[6], reset mid-hold kills the pending repeat.
    pb_raw[2] = 1'b1;
    pb_raw[6] = 1'b1;
    a = cyc + 5;
    expect_ev(K_ACC, 2, a);
    expect_ev(K_ACC, 6, a);
    expect_ev(K_REP, 2, a + 50);
    expect_ev(K_REP, 6, a + 50);
    tick(60);
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    t = cyc;
    expect_ev(K_ACC, 2, t + 5);
    expect_ev(K_ACC, 6, t + 5);
    tick(10);
    pb_raw = '0;
    expect_ev(K_REL, 2, cyc + 5);
    expect_ev(K_REL, 6, cyc + 5);
    tick(12);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL pending_events observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
